// File: rtl/correlator_sched_pkg.sv
// Shared types and constants for the correlator integration scheduler.
// Frame layout: 16 header nibbles, payload nibbles, then 16 footer nibbles.
package correlator_sched_pkg;

    typedef enum logic [1:0] {
        INT_IDLE,
        INT_RUN,
        INT_CLEAR
    } int_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HDR,
        TX_PAY,
        TX_FTR
    } tx_state_e;

    localparam int HDR_NIBBLES = 16;
    localparam int FTR_NIBBLES = 16;

    localparam logic [31:0] FOOTER_MAGIC_DEFAULT = 32'hA5A55A5A;

    function automatic int payload_nibbles(input int payload_size);
        return payload_size / 4;
    endfunction

endpackage

// File: rtl/nibble_serializer.sv
// Parallel-load shift register that emits its top nibble first
// over a valid/ready handshake, counting down the nibbles left.
module nibble_serializer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             ready,
    output logic [3:0]       data,
    output logic             valid,
    output logic             last_nibble,
    output logic             seg_done
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] left_q;
    logic [CNT_W-1:0] left_d;
    logic             xfer;

    assign valid       = (left_q != '0);
    assign last_nibble = (left_q == CNT_W'(1));
    assign xfer        = valid && ready;
    assign seg_done    = xfer && last_nibble;
    assign data        = shreg_q[WIDTH-1 -: 4];

    // A load coincides with the final transfer of the previous
    // segment, so it must win over the shift.
    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        if (load) begin
            shreg_d = load_data;
            left_d  = load_count;
        end else if (xfer) begin
            shreg_d = shreg_q << 4;
            left_d  = left_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            left_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
        end
    end

endmodule

// File: rtl/correlator_scheduler.sv
// Times correlator integration windows, snapshots the accumulators at
// each window boundary and streams the frozen frame out as nibbles.
module correlator_scheduler
    import correlator_sched_pkg::*;
#(
    parameter int          PAYLOAD_SIZE = 1920,
    parameter int          TIMER_WIDTH  = 32,
    parameter logic [31:0] FOOTER_MAGIC = FOOTER_MAGIC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [TIMER_WIDTH-1:0]  integration_ticks,
    input  logic [PAYLOAD_SIZE-1:0] pulses,
    output logic                    corr_enable,
    output logic                    corr_reset,
    output logic [3:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    tx_last,
    output logic                    busy,
    output logic [15:0]             overrun_count,
    output logic [31:0]             frame_count
);

    localparam int PAY_NIB = payload_nibbles(PAYLOAD_SIZE);
    localparam int SER_W   = (PAYLOAD_SIZE > 64) ? PAYLOAD_SIZE : 64;
    localparam int CNT_W   = $clog2(SER_W / 4 + 1);

    int_state_e               int_q, int_d;
    tx_state_e                tx_q, tx_d;
    logic [TIMER_WIDTH-1:0]   cnt_q, cnt_d;
    logic [TIMER_WIDTH-1:0]   ticks_q, ticks_d;
    logic                     full_q, full_d;
    logic [63:0]              ts_q, ts_d;
    logic                     en_q, en_d;
    logic [31:0]              frames_q, frames_d;
    logic [15:0]              over_q, over_d;
    logic [PAYLOAD_SIZE-1:0]  shadow_q, shadow_d;

    logic                     capture;
    logic                     overrun;
    logic                     ser_load;
    logic [SER_W-1:0]         ser_data;
    logic [CNT_W-1:0]         ser_count;
    logic                     ser_last;
    logic                     seg_done;

    // Only a window that ran to its terminal count produces a frame.
    assign capture = (int_q == INT_CLEAR) && full_q && (tx_q == TX_IDLE);
    assign overrun = (int_q == INT_CLEAR) && full_q && (tx_q != TX_IDLE);

    assign ts_d     = ts_q + 64'd1;
    assign en_d     = run;
    assign shadow_d = capture ? pulses : shadow_q;

    always_comb begin
        int_d   = int_q;
        cnt_d   = cnt_q;
        ticks_d = ticks_q;
        full_d  = full_q;
        unique case (int_q)
            INT_IDLE: begin
                cnt_d = '0;
                if (run && integration_ticks != '0) begin
                    int_d   = INT_RUN;
                    ticks_d = integration_ticks;
                end
            end
            INT_RUN: begin
                if (!run) begin
                    int_d  = INT_CLEAR;
                    full_d = 1'b0;
                    cnt_d  = '0;
                end else if (cnt_q == ticks_q - 1'b1) begin
                    int_d  = INT_CLEAR;
                    full_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INT_CLEAR: begin
                cnt_d  = '0;
                full_d = 1'b0;
                if (run && integration_ticks != '0) begin
                    int_d   = INT_RUN;
                    ticks_d = integration_ticks;
                end else begin
                    int_d = INT_IDLE;
                end
            end
            default: int_d = INT_IDLE;
        endcase
    end

    // Each segment is queued on the edge its predecessor finishes,
    // so a ready transmitter sees one nibble per cycle.
    always_comb begin
        tx_d      = tx_q;
        frames_d  = frames_q;
        over_d    = over_q;
        ser_load  = 1'b0;
        ser_data  = '0;
        ser_count = '0;
        if (overrun && over_q != 16'hFFFF) begin
            over_d = over_q + 16'd1;
        end
        unique case (tx_q)
            TX_IDLE: begin
                if (capture) begin
                    ser_load                 = 1'b1;
                    ser_data[SER_W-1 -: 64]  = ts_q;
                    ser_count                = CNT_W'(HDR_NIBBLES);
                    tx_d                     = TX_HDR;
                end
            end
            TX_HDR: begin
                if (seg_done) begin
                    ser_load                          = 1'b1;
                    ser_data[SER_W-1 -: PAYLOAD_SIZE] = shadow_q;
                    ser_count                         = CNT_W'(PAY_NIB);
                    tx_d                              = TX_PAY;
                end
            end
            TX_PAY: begin
                if (seg_done) begin
                    ser_load                = 1'b1;
                    ser_data[SER_W-1 -: 64] = {frames_q + 32'd1, FOOTER_MAGIC};
                    ser_count               = CNT_W'(FTR_NIBBLES);
                    tx_d                    = TX_FTR;
                end
            end
            TX_FTR: begin
                if (seg_done) begin
                    frames_d = frames_q + 32'd1;
                    tx_d     = TX_IDLE;
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int_q    <= INT_IDLE;
            tx_q     <= TX_IDLE;
            cnt_q    <= '0;
            ticks_q  <= '0;
            full_q   <= 1'b0;
            ts_q     <= '0;
            en_q     <= 1'b0;
            frames_q <= '0;
            over_q   <= '0;
        end else begin
            int_q    <= int_d;
            tx_q     <= tx_d;
            cnt_q    <= cnt_d;
            ticks_q  <= ticks_d;
            full_q   <= full_d;
            ts_q     <= ts_d;
            en_q     <= en_d;
            frames_q <= frames_d;
            over_q   <= over_d;
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    nibble_serializer #(
        .WIDTH (SER_W),
        .CNT_W (CNT_W)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load        (ser_load),
        .load_data   (ser_data),
        .load_count  (ser_count),
        .ready       (tx_ready),
        .data        (tx_data),
        .valid       (tx_valid),
        .last_nibble (ser_last),
        .seg_done    (seg_done)
    );

    assign corr_enable   = en_q;
    assign corr_reset    = reset || (int_q == INT_CLEAR);
    assign tx_last       = (tx_q == TX_FTR) && ser_last;
    assign busy          = (tx_q != TX_IDLE);
    assign overrun_count = over_q;
    assign frame_count   = frames_q;

endmodule
